// File: rtl/rvfi_retire_serializer.sv
// Serialises NRET parallel RVFI retire channels into one in-order ready/valid stream via a circular buffer.
// Optional RVFI_SERIALIZER_ORDER_CHECK_EN adds a sticky order_err output tracking rvfi_order continuity.
module rvfi_retire_serializer #(
  parameter int NRET    = 2,
  parameter int XLEN    = 32,
  parameter int ORDER_W = 8,
  parameter int DEPTH   = 8
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NRET-1:0]           rvfi_valid,
  input  logic [NRET*ORDER_W-1:0]   rvfi_order,
  input  logic [NRET*32-1:0]        rvfi_insn,
  input  logic [NRET*XLEN-1:0]      rvfi_pre_pc,
  input  logic [NRET*XLEN-1:0]      rvfi_post_pc,
  input  logic [NRET-1:0]           rvfi_trap,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ORDER_W-1:0]        out_order,
  output logic [31:0]               out_insn,
  output logic [XLEN-1:0]           out_pre_pc,
  output logic [XLEN-1:0]           out_post_pc,
  output logic                      out_trap,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow
`ifdef RVFI_SERIALIZER_ORDER_CHECK_EN
  ,
  output logic                      order_err
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [ORDER_W-1:0] order_mem [DEPTH];
  logic [31:0]        insn_mem  [DEPTH];
  logic [XLEN-1:0]    pre_mem   [DEPTH];
  logic [XLEN-1:0]    post_mem  [DEPTH];
  logic               trap_mem  [DEPTH];

  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [LW-1:0] level_r;
  logic          out_valid_r;
  logic          overflow_r;

  logic          pop_s;
  logic          accept_s;
  logic [LW-1:0] n_s;
  logic [LW:0]   total_s;
  logic [LW-1:0] level_nxt_s;
  logic [PW-1:0] slot_s [NRET];

  assign pop_s = out_valid_r & out_ready;

  // Compact valid channels: each valid channel takes the next free slot after wr_ptr.
  always_comb begin
    n_s = '0;
    for (int i = 0; i < NRET; i++) begin
      slot_s[i] = wr_ptr_r + n_s[PW-1:0];
      if (rvfi_valid[i]) begin
        n_s = n_s + LW'(1);
      end else begin
        n_s = n_s;
      end
    end
  end

  // Space check counts a same-cycle pop as already freed; a rejected group only loses the pop.
  always_comb begin
    total_s  = {1'b0, level_r} + {1'b0, n_s} - {{LW{1'b0}}, pop_s};
    accept_s = (total_s <= (LW+1)'(DEPTH));
    if (accept_s) begin
      level_nxt_s = total_s[LW-1:0];
    end else begin
      level_nxt_s = level_r - {{PW{1'b0}}, pop_s};
    end
  end

  // Pointer, occupancy and sticky overflow state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      level_r     <= '0;
      out_valid_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      level_r     <= level_nxt_s;
      out_valid_r <= (level_nxt_s != '0);
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      if (accept_s) begin
        wr_ptr_r <= wr_ptr_r + n_s[PW-1:0];
      end else begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Buffer storage; contents need no reset since level gates visibility.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NRET; i++) begin
      if (accept_s && rvfi_valid[i]) begin
        order_mem[slot_s[i]] <= rvfi_order[i*ORDER_W +: ORDER_W];
        insn_mem[slot_s[i]]  <= rvfi_insn[i*32 +: 32];
        pre_mem[slot_s[i]]   <= rvfi_pre_pc[i*XLEN +: XLEN];
        post_mem[slot_s[i]]  <= rvfi_post_pc[i*XLEN +: XLEN];
        trap_mem[slot_s[i]]  <= rvfi_trap[i];
      end
    end
  end

  assign out_valid   = out_valid_r;
  assign out_order   = order_mem[rd_ptr_r];
  assign out_insn    = insn_mem[rd_ptr_r];
  assign out_pre_pc  = pre_mem[rd_ptr_r];
  assign out_post_pc = post_mem[rd_ptr_r];
  assign out_trap    = trap_mem[rd_ptr_r];
  assign level       = level_r;
  assign overflow    = overflow_r;

`ifdef RVFI_SERIALIZER_ORDER_CHECK_EN
  logic [ORDER_W-1:0] exp_order_r;
  logic               exp_loaded_r;
  logic               order_err_r;
  logic [ORDER_W-1:0] exp_next_s;

  assign exp_next_s = exp_order_r + ORDER_W'(1);

  // Expected order re-syncs to each popped value so one gap flags once, not forever.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      exp_order_r  <= '0;
      exp_loaded_r <= 1'b0;
      order_err_r  <= 1'b0;
    end else if (pop_s) begin
      if (exp_loaded_r && (out_order != exp_next_s)) begin
        order_err_r <= 1'b1;
      end
      exp_order_r  <= out_order;
      exp_loaded_r <= 1'b1;
    end
  end

  assign order_err = order_err_r;

`ifdef FORMAL
  rvfi_retire_serializer_order_chk #(.ORDER_W(ORDER_W)) u_order_chk (
    .clk           (clk),
    .resetn        (resetn),
    .check         (pop_s & exp_loaded_r),
    .order         (out_order),
    .expected_next (exp_next_s)
  );
`endif
`endif

endmodule

`ifdef RVFI_SERIALIZER_ORDER_CHECK_EN
`ifdef FORMAL
module rvfi_retire_serializer_order_chk #(
  parameter int ORDER_W = 8
) (
  input logic               clk,
  input logic               resetn,
  input logic               check,
  input logic [ORDER_W-1:0] order,
  input logic [ORDER_W-1:0] expected_next
);
  // Every popped order after the first must be the successor of the previous one.
  always_ff @(posedge clk) begin
    if (resetn && check) begin
      assert (order == expected_next);
    end
  end
endmodule
`endif
`endif
